// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// video_pkg -- shared widths, marker colour and overlay latency constants.
// Rev 1.0
// ============================================================================
package video_pkg;

  localparam int DEF_PIXEL_WIDTH = 8;
  localparam int DEF_COORD_WIDTH = 12;

  localparam logic [7:0] DEF_MARK_R = 8'hFF;
  localparam logic [7:0] DEF_MARK_G = 8'h00;
  localparam logic [7:0] DEF_MARK_B = 8'h00;

  // Sideband blocks that run alongside the overlay delay by this many cycles.
  localparam int OVERLAY_LATENCY = 2;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

endpackage
`default_nettype wire

// File: rtl/video_pos_counter.sv
`default_nettype none
// ============================================================================
// video_pos_counter -- raster x/y tracking from VSYNC/DE edges, saturating.
// Rev 1.0
// ============================================================================
module video_pos_counter
  import video_pkg::*;
#(
  parameter int COORD_WIDTH = DEF_COORD_WIDTH
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   iVSYNC,
  input  logic                   iDE,
  output logic [COORD_WIDTH-1:0] oX,
  output logic [COORD_WIDTH-1:0] oY,
  output logic                   oFRAME_START
);

  localparam logic [COORD_WIDTH-1:0] C_MAX = '1;

  logic r_vs_d;
  logic r_de_d;
  logic w_line_end;
  logic [COORD_WIDTH-1:0] r_x;
  logic [COORD_WIDTH-1:0] r_y;

  assign oFRAME_START = iVSYNC & ~r_vs_d;
  assign w_line_end   = ~iDE & r_de_d;
  assign oX           = r_x;
  assign oY           = r_y;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_vs_d <= 1'b0;
      r_de_d <= 1'b0;
      r_x    <= '0;
      r_y    <= '0;
    end else begin
      r_vs_d <= iVSYNC;
      r_de_d <= iDE;

      if (oFRAME_START || w_line_end)
        r_x <= '0;
      else if (iDE && (r_x != C_MAX))
        r_x <= r_x + 1'b1;

      // Frame start outranks a coincident line end so the next line is y=0.
      if (oFRAME_START)
        r_y <= '0;
      else if (w_line_end && (r_y != C_MAX))
        r_y <= r_y + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/video_marker_overlay.sv
`default_nettype none
// ============================================================================
// video_marker_overlay -- draws a crosshair at the pupil coordinate, 2-cycle
// pipeline with sync/DE delay-matched. Rev 1.0
// ============================================================================
module video_marker_overlay
  import video_pkg::*;
#(
  parameter int                     PIXEL_WIDTH = DEF_PIXEL_WIDTH,
  parameter int                     COORD_WIDTH = DEF_COORD_WIDTH,
  parameter int                     ARM_LEN     = 8,
  parameter logic [PIXEL_WIDTH-1:0] MARK_R      = PIXEL_WIDTH'(DEF_MARK_R),
  parameter logic [PIXEL_WIDTH-1:0] MARK_G      = PIXEL_WIDTH'(DEF_MARK_G),
  parameter logic [PIXEL_WIDTH-1:0] MARK_B      = PIXEL_WIDTH'(DEF_MARK_B)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   iHSYNC,
  input  logic                   iVSYNC,
  input  logic                   iDE,
  input  logic [PIXEL_WIDTH-1:0] iR0,
  input  logic [PIXEL_WIDTH-1:0] iG0,
  input  logic [PIXEL_WIDTH-1:0] iB0,
  input  logic [COORD_WIDTH-1:0] iMX,
  input  logic [COORD_WIDTH-1:0] iMY,
  input  logic                   iMEN,
  output logic                   oHSYNC,
  output logic                   oVSYNC,
  output logic                   oDE,
  output logic [PIXEL_WIDTH-1:0] oR0,
  output logic [PIXEL_WIDTH-1:0] oG0,
  output logic [PIXEL_WIDTH-1:0] oB0
);

  localparam logic signed [COORD_WIDTH:0] C_ARM = (COORD_WIDTH + 1)'(ARM_LEN);

  logic [COORD_WIDTH-1:0] w_x;
  logic [COORD_WIDTH-1:0] w_y;
  logic                   w_frame_start;

  logic [COORD_WIDTH-1:0] r_mx;
  logic [COORD_WIDTH-1:0] r_my;
  logic                   r_men;

  logic signed [COORD_WIDTH:0] w_dx;
  logic signed [COORD_WIDTH:0] w_dy;
  logic                        w_hit_h;
  logic                        w_hit_v;

  sync_t                  r_sync1;
  sync_t                  r_sync2;
  logic                   r_mark1;
  logic [PIXEL_WIDTH-1:0] r_r1, r_g1, r_b1;
  logic [PIXEL_WIDTH-1:0] r_r2, r_g2, r_b2;

  video_pos_counter #(
    .COORD_WIDTH (COORD_WIDTH)
  ) u_pos (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .iVSYNC       (iVSYNC),
    .iDE          (iDE),
    .oX           (w_x),
    .oY           (w_y),
    .oFRAME_START (w_frame_start)
  );

  // One extra bit keeps the differences signed without wrap-around aliasing.
  assign w_dx    = $signed({1'b0, w_x}) - $signed({1'b0, r_mx});
  assign w_dy    = $signed({1'b0, w_y}) - $signed({1'b0, r_my});
  assign w_hit_h = (w_y == r_my) && (w_dx <= C_ARM) && (w_dx >= -C_ARM);
  assign w_hit_v = (w_x == r_mx) && (w_dy <= C_ARM) && (w_dy >= -C_ARM);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mx    <= '0;
      r_my    <= '0;
      r_men   <= 1'b0;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_mark1 <= 1'b0;
      r_r1    <= '0;
      r_g1    <= '0;
      r_b1    <= '0;
      r_r2    <= '0;
      r_g2    <= '0;
      r_b2    <= '0;
    end else begin
      if (w_frame_start) begin
        r_mx  <= iMX;
        r_my  <= iMY;
        r_men <= iMEN;
      end

      r_sync1 <= '{hs: iHSYNC, vs: iVSYNC, de: iDE};
      r_mark1 <= r_men & iDE & (w_hit_h | w_hit_v);
      r_r1    <= iR0;
      r_g1    <= iG0;
      r_b1    <= iB0;

      r_sync2 <= r_sync1;
      r_r2    <= r_mark1 ? MARK_R : r_r1;
      r_g2    <= r_mark1 ? MARK_G : r_g1;
      r_b2    <= r_mark1 ? MARK_B : r_b1;
    end
  end

  assign oHSYNC = r_sync2.hs;
  assign oVSYNC = r_sync2.vs;
  assign oDE    = r_sync2.de;
  assign oR0    = r_r2;
  assign oG0    = r_g2;
  assign oB0    = r_b2;

endmodule
`default_nettype wire

// File: tb/tb_video_marker_overlay.sv
`default_nettype none
// ============================================================================
// tb_video_marker_overlay -- randomized raster stimulus against a frame-level
// reference model, plus a table of marker placements with red-pixel counts.
// Rev 1.0
// ============================================================================
module tb_video_marker_overlay;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } px_t;

  typedef struct {
    string name;
    bit    men;
    int    mx;
    int    my;
    int    exp_red;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        iHSYNC = 1'b0, iVSYNC = 1'b0, iDE = 1'b0;
  logic [7:0]  iR0 = '0, iG0 = '0, iB0 = '0;
  logic [11:0] iMX = '0, iMY = '0;
  logic        iMEN = 1'b0;
  logic        oHSYNC, oVSYNC, oDE;
  logic [7:0]  oR0, oG0, oB0;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  red_cnt = 0;
  bit  tb_rst_n = 1'b0;

  px_t pipe [2];
  int  m_men = 0, m_mx = 0, m_my = 0;
  bit  m_prev_vs = 1'b0;

  always #5 CLK = ~CLK;

  video_marker_overlay dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .iHSYNC (iHSYNC),
    .iVSYNC (iVSYNC),
    .iDE    (iDE),
    .iR0    (iR0),
    .iG0    (iG0),
    .iB0    (iB0),
    .iMX    (iMX),
    .iMY    (iMY),
    .iMEN   (iMEN),
    .oHSYNC (oHSYNC),
    .oVSYNC (oVSYNC),
    .oDE    (oDE),
    .oR0    (oR0),
    .oG0    (oG0),
    .oB0    (oB0)
  );

  function automatic int clamp(input int v);
    return (v > 4095) ? 4095 : v;
  endfunction

  function automatic bit on_cross(input int x, input int y);
    bit h, v;
    h = (y == m_my) && (x - m_mx <= 8) && (m_mx - x <= 8);
    v = (x == m_mx) && (y - m_my <= 8) && (m_my - y <= 8);
    return h || v;
  endfunction

  // One pixel clock: check the output due now, then drive the next input.
  task automatic step(input logic hs, input logic vs, input logic de,
                      input int x, input int y);
    px_t got, e;
    @(negedge CLK);
    got = '{hs: oHSYNC, vs: oVSYNC, de: oDE, r: oR0, g: oG0, b: oB0};
    n_tests++;
    if (got !== pipe[1]) begin
      n_fail++;
      $display("FAIL pixel t=%0t got %h want %h", $time, got, pipe[1]);
    end
    if (oDE === 1'b1 && oR0 == 8'hFF && oG0 == 8'h00 && oB0 == 8'h00)
      red_cnt++;
    pipe[1] = pipe[0];

    iHSYNC = hs;
    iVSYNC = vs;
    iDE    = de;
    iR0    = 8'($urandom_range(0, 254));
    iG0    = 8'($urandom);
    iB0    = 8'($urandom);
    RST_N  = tb_rst_n;

    e = '{hs: hs, vs: vs, de: de, r: iR0, g: iG0, b: iB0};
    if (!tb_rst_n) begin
      e = '0;
      pipe[1] = '0;
      m_men = 0; m_mx = 0; m_my = 0;
      m_prev_vs = 1'b0;
    end else begin
      if (de && m_men != 0 && on_cross(x, y)) begin
        e.r = 8'hFF; e.g = 8'h00; e.b = 8'h00;
      end
      if (vs && !m_prev_vs) begin
        m_men = int'(iMEN); m_mx = int'(iMX); m_my = int'(iMY);
      end
      m_prev_vs = vs;
    end
    pipe[0] = e;
  endtask

  task automatic vsync_pulse();
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
  endtask

  task automatic lines(input int w, input int h, input int chg_line, input int chg_mx);
    for (int l = 0; l < h; l++) begin
      if (l == chg_line) iMX = 12'(chg_mx);
      for (int i = 0; i < w; i++) step(0, 0, 1, clamp(i), clamp(l));
      step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    end
  endtask

  task automatic check_red(input string name, input int exp);
    n_tests++;
    if (red_cnt != exp) begin
      n_fail++;
      $display("FAIL %s red pixels got %0d want %0d", name, red_cnt, exp);
    end
    red_cnt = 0;
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{"passthrough", 1'b0, 20, 10, 0};
    vecs[1] = '{"crosshair",   1'b1, 20, 10, 33};
    vecs[2] = '{"edge_clip",   1'b1,  2,  0, 19};
    vecs[3] = '{"corner",      1'b1, 63, 47, 17};
    vecs[4] = '{"offscreen",   1'b1, 100, 10, 0};
    vecs[5] = '{"near_br",     1'b1, 60, 45, 22};
    pipe[0] = '0;
    pipe[1] = '0;

    // Reset with random activity, marker armed before any frame start.
    tb_rst_n = 1'b0;
    for (int i = 0; i < 5; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), 0, 0);
    iMEN = 1'b1; iMX = 12'd20; iMY = 12'd10;
    tb_rst_n = 1'b1;
    red_cnt = 0;
    lines(64, 48, -1, 0);
    check_red("reset_frame1", 0);
    vsync_pulse();
    red_cnt = 0;
    lines(64, 48, -1, 0);
    check_red("reset_frame2", 33);

    for (int k = 0; k < 6; k++) begin
      iMEN = vecs[k].men;
      iMX  = 12'(vecs[k].mx);
      iMY  = 12'(vecs[k].my);
      vsync_pulse();
      red_cnt = 0;
      lines(64, 48, -1, 0);
      check_red(vecs[k].name, vecs[k].exp_red);
    end

    // Marker x changed mid-frame: takes effect only after the next frame start.
    iMEN = 1'b1; iMX = 12'd20; iMY = 12'd10;
    vsync_pulse();
    red_cnt = 0;
    lines(64, 48, 5, 40);
    check_red("midframe_old", 33);
    vsync_pulse();
    red_cnt = 0;
    lines(64, 48, -1, 0);
    check_red("midframe_new", 33);

    // 5000-pixel line: x holds at 4095, so every saturated pixel hits mx=4095.
    iMEN = 1'b1; iMX = 12'd4095; iMY = 12'd0;
    vsync_pulse();
    red_cnt = 0;
    for (int i = 0; i < 5000; i++) step(0, 0, 1, clamp(i), 0);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    check_red("saturation", 913);

    // Frame start in the same cycle as a DE falling edge.
    iMEN = 1'b0;
    vsync_pulse();
    iMEN = 1'b1; iMX = 12'd5; iMY = 12'd0;
    red_cnt = 0;
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 64; i++) step(0, 0, 1, i, l);
      if (l < 2) begin
        step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
      end
    end
    step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    check_red("collision_pre", 0);
    lines(64, 12, -1, 0);
    check_red("collision_y0", 22);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
